// File: rtl/board_pkg.sv
// Shared types and board geometry for the board packet unpacker.
// Holds the cell code enum, FSM states and a cell decode helper.
package board_pkg;

    localparam int BOARD_DIM   = 9;
    localparam int BOARD_CELLS = 81;
    localparam int PKT_BITS    = 162;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        BLACK   = 2'b01,
        WHITE   = 2'b10,
        INVALID = 2'b11
    } cell_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } unpack_state_t;

    // {illegal, code}: illegal codes are replaced by EMPTY
    function automatic logic [2:0] unpack_cell(input logic [1:0] c);
        logic bad;
        bad = (c == INVALID);
        return {bad, bad ? EMPTY : c};
    endfunction

endpackage

// File: rtl/board_pkt_unpacker_if.sv
// Cell stream handshake from the unpacker into board storage.
// master = cell source, slave = board storage.
interface board_pkt_unpacker_if;

    logic [6:0] cell_addr_out;
    logic [1:0] cell_data_out;
    logic       cell_valid_out;
    logic       cell_ready_in;

    modport master (
        output cell_addr_out,
        output cell_data_out,
        output cell_valid_out,
        input  cell_ready_in
    );

    modport slave (
        input  cell_addr_out,
        input  cell_data_out,
        input  cell_valid_out,
        output cell_ready_in
    );

endinterface

// File: rtl/board_pkt_unpacker_rise_detect.sv
// One-flop rising-edge detector with configurable reset value.
// A reset value of 1 hides a level that is already high at release.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic sig,
    output logic rise
);

    logic last;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) last <= RST_VAL;
        else           last <= sig;
    end

    assign rise = sig & ~last;

endmodule

// File: rtl/board_pkt_unpacker.sv
// Snapshots a 162-bit board packet and streams its 81 cells.
// Define STONE_COUNT_EN to enable the black/white stone counters.
module board_pkt_unpacker #(
    parameter int PKT_LNGTH = 162,
    parameter int BOARD_DIM = 9
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [PKT_LNGTH-1:0] pkt_in,
    input  logic                 pkt_ready_in,
    board_pkt_unpacker_if.master cell_if,
    output logic                 busy_out,
    output logic                 frame_done_out,
    output logic                 err_out,
    output logic                 dropped_out,
    output logic [6:0]           black_count_out,
    output logic [6:0]           white_count_out
);

    import board_pkg::*;

    localparam int LAST = BOARD_DIM * BOARD_DIM - 1;

    unpack_state_t        state;
    unpack_state_t        state_nxt;
    logic                 rise;
    logic                 accept;
    logic                 last_cell;
    logic                 capture;
    logic [6:0]           idx;
    logic [PKT_LNGTH-1:0] snap;
    logic [1:0]           data_q;
    logic                 bad_q;
    logic                 err_q;
    logic                 drop_q;
    logic [1:0]           nxt_code;

    rise_detect #(.RST_VAL(1'b1)) u_rise (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .sig      (pkt_ready_in),
        .rise     (rise)
    );

    assign accept    = (state == STREAM) && cell_if.cell_ready_in;
    assign last_cell = (idx == 7'(LAST));
    assign capture   = (state == IDLE) && rise;
    assign nxt_code  = snap[{idx + 7'd1, 1'b0} +: 2];

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = STREAM;
            STREAM:  if (accept && last_cell) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Cell data is pre-fetched so address and data change together
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            idx    <= '0;
            snap   <= '0;
            data_q <= '0;
            bad_q  <= 1'b0;
            err_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            drop_q <= rise && (state != IDLE);
            if (capture) begin
                idx             <= '0;
                snap            <= pkt_in;
                {bad_q, data_q} <= unpack_cell(pkt_in[1:0]);
                err_q           <= 1'b0;
            end else if (accept) begin
                if (bad_q) err_q <= 1'b1;
                if (!last_cell) begin
                    idx             <= idx + 7'd1;
                    {bad_q, data_q} <= unpack_cell(nxt_code);
                end
            end
        end
    end

`ifdef STONE_COUNT_EN
    logic [6:0] black_q;
    logic [6:0] white_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || capture) begin
            black_q <= '0;
            white_q <= '0;
        end else if (accept) begin
            if (data_q == BLACK) black_q <= black_q + 7'd1;
            if (data_q == WHITE) white_q <= white_q + 7'd1;
        end
    end

    assign black_count_out = black_q;
    assign white_count_out = white_q;
`else
    assign black_count_out = '0;
    assign white_count_out = '0;
`endif

    assign cell_if.cell_addr_out  = idx;
    assign cell_if.cell_data_out  = data_q;
    assign cell_if.cell_valid_out = (state == STREAM);
    assign busy_out               = (state != IDLE);
    assign frame_done_out         = (state == DONE);
    assign err_out                = err_q;
    assign dropped_out            = drop_q;

endmodule

// File: tb/tb_board_pkt_unpacker.sv
// Directed bench for board_pkt_unpacker: frames, stalls, bad codes,
// drops and resets, checked against hand-derived expectations.
module tb_board_pkt_unpacker;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic [161:0] pkt_in;
    logic         pkt_ready_in;
    logic         busy_out;
    logic         frame_done_out;
    logic         err_out;
    logic         dropped_out;
    logic [6:0]   black_count_out;
    logic [6:0]   white_count_out;

    int n_vec = 0;
    int n_bad = 0;

`ifdef STONE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    board_pkt_unpacker_if cif ();

    board_pkt_unpacker #(.PKT_LNGTH(162), .BOARD_DIM(9)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .pkt_in          (pkt_in),
        .pkt_ready_in    (pkt_ready_in),
        .cell_if         (cif),
        .busy_out        (busy_out),
        .frame_done_out  (frame_done_out),
        .err_out         (err_out),
        .dropped_out     (dropped_out),
        .black_count_out (black_count_out),
        .white_count_out (white_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [161:0] mk_pkt(input int shift, input bit bad);
        logic [161:0] p;
        p = '0;
        for (int k = 0; k < 81; k++) p[2*k +: 2] = 2'((k + shift) % 3);
        if (bad) begin
            p[11:10]   = 2'b11;
            p[161:160] = 2'b11;
        end
        return p;
    endfunction

    function automatic logic [1:0] exp_code(input logic [161:0] p, input int k);
        logic [1:0] c;
        c = p[2*k +: 2];
        return (c == 2'b11) ? 2'b00 : c;
    endfunction

    // One full frame starting from IDLE with pkt_ready_in low
    task automatic run_frame(input logic [161:0] p, input logic [161:0] p2,
                             input bit bp, input int drop_at, input bit bad,
                             input int blk, input int wht);
        int k, stalls, t, done_t, drop_t, drop_seen, n_drop;
        k = 0; stalls = 0; t = 1; done_t = -1;
        drop_t = -1; drop_seen = -1; n_drop = 0;
        pkt_in       = p;
        pkt_ready_in = 1'b1;
        tick();
        pkt_ready_in = 1'b0;
        while (t < 400 && done_t < 0) begin
            cif.cell_ready_in = bp ? (t % 2 == 0) : 1'b1;
            if (k <= 80) begin
                chk($sformatf("valid[%0d]", k), cif.cell_valid_out, 1);
                chk($sformatf("addr[%0d]", k), cif.cell_addr_out, k);
                chk($sformatf("data[%0d]", k), cif.cell_data_out, exp_code(p, k));
                chk($sformatf("err[%0d]", k), err_out, bad && k > 5);
            end
            if (frame_done_out) done_t = t;
            if (dropped_out) begin
                n_drop++;
                drop_seen = t;
            end
            if (drop_t >= 0 && t == drop_t + 1) pkt_ready_in = 1'b0;
            if (drop_at >= 0 && drop_t < 0 && k == drop_at) begin
                pkt_in       = p2;
                pkt_ready_in = 1'b1;
                drop_t       = t;
            end
            if (cif.cell_valid_out && cif.cell_ready_in) k++;
            else if (cif.cell_valid_out) stalls++;
            if (done_t < 0) begin
                tick();
                t++;
            end
        end
        pkt_ready_in = 1'b0;
        chk("done_cycle", done_t, 82 + stalls);
        chk("cells_accepted", k, 81);
        chk("err_at_done", err_out, bad);
        chk("black_at_done", black_count_out, CNT_EN ? blk : 0);
        chk("white_at_done", white_count_out, CNT_EN ? wht : 0);
        chk("drop_pulses", n_drop, drop_at >= 0 ? 1 : 0);
        if (drop_at >= 0) chk("drop_cycle", drop_seen, drop_t + 1);
        if (bp) chk("stalls_seen", stalls > 40, 1);
        tick();
        chk("done_low", frame_done_out, 0);
        chk("idle_busy", busy_out, 0);
        chk("err_held", err_out, bad);
        chk("black_held", black_count_out, CNT_EN ? blk : 0);
        tick();
        chk("no_second_done", frame_done_out, 0);
    endtask

    initial begin
        logic [161:0] p0, p1, p2;
        p0 = mk_pkt(0, 1'b0);
        p1 = mk_pkt(0, 1'b1);
        p2 = mk_pkt(1, 1'b0);

        rst_n_in          = 1'b0;
        pkt_in            = p0;
        pkt_ready_in      = 1'b1;
        cif.cell_ready_in = 1'b1;
        tick();
        tick();
        chk("rst_valid", cif.cell_valid_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", frame_done_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_drop", dropped_out, 0);
        chk("rst_addr", cif.cell_addr_out, 0);
        chk("rst_data", cif.cell_data_out, 0);
        chk("rst_black", black_count_out, 0);
        chk("rst_white", white_count_out, 0);

        rst_n_in = 1'b1;
        tick();
        tick();
        tick();
        chk("hi_at_release_busy", busy_out, 0);
        chk("hi_at_release_valid", cif.cell_valid_out, 0);
        pkt_ready_in = 1'b0;
        tick();

        run_frame(p0, p2, 1'b0, -1, 1'b0, 27, 27);
        run_frame(p0, p2, 1'b1, -1, 1'b0, 27, 27);
        run_frame(p1, p2, 1'b0, -1, 1'b1, 27, 25);
        run_frame(p0, p2, 1'b0, 40, 1'b0, 27, 27);

        pkt_in       = p1;
        pkt_ready_in = 1'b1;
        tick();
        pkt_ready_in      = 1'b0;
        cif.cell_ready_in = 1'b1;
        for (int i = 0; i < 200 && cif.cell_addr_out != 7'd30; i++) tick();
        chk("mid_addr30", cif.cell_addr_out, 30);
        chk("mid_err", err_out, 1);
        rst_n_in = 1'b0;
        tick();
        chk("mid_rst_valid", cif.cell_valid_out, 0);
        chk("mid_rst_busy", busy_out, 0);
        chk("mid_rst_err", err_out, 0);
        chk("mid_rst_black", black_count_out, 0);
        chk("mid_rst_white", white_count_out, 0);
        chk("mid_rst_addr", cif.cell_addr_out, 0);
        rst_n_in = 1'b1;
        tick();
        chk("post_rst_idle", busy_out, 0);

        run_frame(p2, p0, 1'b0, -1, 1'b0, 27, 27);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
